// File: rtl/regional_router.sv
// Region router: decodes addr_i[27:20] into a one-cycle ICB strobe and returns a registered response.
// Optional WAIT-state timeout with error response is enabled by defining REGIONAL_TIMEOUT_EN.
module regional_router #(
  parameter int NREG   = 4,
  parameter int TO_CYC = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          data_i,
  output logic [31:0]          data_o,
  output logic                 ack_o,
  output logic                 err_o,
  output logic [NREG-1:0]      icb_wr,
  output logic [NREG-1:0]      icb_rd,
  output logic [19:0]          icb_adr,
  output logic [31:0]          icb_wdat,
  input  logic [NREG-1:0]      icb_ack,
  input  logic [NREG*32-1:0]   icb_rdat
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_ERR} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic        mapped_q, mapped_d;
  logic [7:0]  sel_q, sel_d;
  logic [19:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] data_q, data_d;
  logic        req_mapped;
  logic        sel_ack;
  logic [31:0] sel_rdat;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^addr_i[31:28];
  assign req_mapped     = ({1'b0, addr_i[27:20]} < 9'(NREG));

`ifdef REGIONAL_TIMEOUT_EN
  localparam int CW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
`else
  localparam int unused_to_cyc = TO_CYC;
`endif

  // Only the selected region's ack/data matter; everything else is ignored.
  always_comb begin
    sel_ack  = 1'b0;
    sel_rdat = '0;
    for (int k = 0; k < NREG; k++) begin
      if (sel_q == 8'(k)) begin
        sel_ack  = icb_ack[k];
        sel_rdat = icb_rdat[k*32 +: 32];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    mapped_d = mapped_q;
    sel_d    = sel_q;
    adr_d    = adr_q;
    wdat_d   = wdat_q;
    data_d   = data_q;
`ifdef REGIONAL_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          we_d     = we_i;
          sel_d    = addr_i[27:20];
          adr_d    = addr_i[19:0];
          wdat_d   = data_i;
          mapped_d = req_mapped;
          state_d  = S_ISSUE;
        end
      end
      // Unmapped accesses pass through ISSUE with strobes suppressed so the
      // error lands at the same latency as a zero-wait access.
      S_ISSUE: begin
        if (!mapped_q) begin
          state_d = S_ERR;
          data_d  = '0;
        end else if (sel_ack) begin
          state_d = S_RESP;
          data_d  = we_q ? 32'h0 : sel_rdat;
        end else begin
          state_d = S_WAIT;
`ifdef REGIONAL_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WAIT: begin
        if (sel_ack) begin
          state_d = S_RESP;
          data_d  = we_q ? 32'h0 : sel_rdat;
        end
`ifdef REGIONAL_TIMEOUT_EN
        else if (cnt_q == CW'(TO_CYC - 1)) begin
          state_d = S_ERR;
          data_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      mapped_q <= 1'b0;
      sel_q    <= '0;
      adr_q    <= '0;
      wdat_q   <= '0;
      data_q   <= '0;
`ifdef REGIONAL_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      mapped_q <= mapped_d;
      sel_q    <= sel_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      data_q   <= data_d;
`ifdef REGIONAL_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  always_comb begin
    icb_wr = '0;
    icb_rd = '0;
    for (int k = 0; k < NREG; k++) begin
      if (state_q == S_ISSUE && mapped_q && sel_q == 8'(k)) begin
        icb_wr[k] = we_q;
        icb_rd[k] = !we_q;
      end
    end
  end

  assign ack_o    = (state_q == S_RESP) || (state_q == S_ERR);
  assign err_o    = (state_q == S_ERR);
  assign data_o   = data_q;
  assign icb_adr  = adr_q;
  assign icb_wdat = wdat_q;

endmodule

// File: tb/tb_regional_router.sv
// Randomized self-checking bench for regional_router against a transaction-level latency/data model.
module tb_regional_router;
  localparam int NREG   = 4;
  localparam int TO_CYC = 15;
  localparam int NEVER  = 1000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 req_i, we_i;
  logic [31:0]          addr_i, data_i, data_o;
  logic                 ack_o, err_o;
  logic [NREG-1:0]      icb_wr, icb_rd, icb_ack;
  logic [19:0]          icb_adr;
  logic [31:0]          icb_wdat;
  logic [NREG*32-1:0]   icb_rdat;

  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] last_data = 32'h0;

  regional_router #(.NREG(NREG), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
    .data_o(data_o), .ack_o(ack_o), .err_o(err_o), .icb_wr(icb_wr), .icb_rd(icb_rd),
    .icb_adr(icb_adr), .icb_wdat(icb_wdat), .icb_ack(icb_ack), .icb_rdat(icb_rdat)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      req_i = 1'b0; we_i = 1'($urandom); addr_i = $urandom; data_i = $urandom;
      icb_ack = NREG'($urandom);
      @(negedge clk);
      vectors++;
      if (ack_o !== 1'b0 || icb_wr !== '0 || icb_rd !== '0 || data_o !== last_data) begin
        errors++;
        $display("FAIL idle: ack=%b wr=%b rd=%b data=%h, want ack=0 wr=0 rd=0 data=%h",
                 ack_o, icb_wr, icb_rd, data_o, last_data);
      end
    end
  endtask

  // Model: mapped access responds 2+d cycles after request (d = slave delay
  // after strobe); unmapped responds at 2 with error; timeout caps at 2+TO_CYC.
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input int d, input logic [31:0] rd);
    int              r, ack_cyc;
    bit              mapped, exp_err;
    logic [NREG-1:0] oh, a, exp_wr, exp_rd;
    logic [31:0]     exp_data, exp_d;
    logic            exp_ack;
    r       = int'(addr[27:20]);
    mapped  = (r < NREG);
    oh      = '0;
    if (mapped) oh[r] = 1'b1;
    exp_err = !mapped;
    ack_cyc = mapped ? 2 + d : 2;
`ifdef REGIONAL_TIMEOUT_EN
    if (mapped && d > TO_CYC) begin ack_cyc = 2 + TO_CYC; exp_err = 1'b1; end
`endif
    exp_data = (exp_err || we) ? 32'h0 : rd;
    for (int k = 0; k < NREG; k++) icb_rdat[k*32 +: 32] = $urandom;
    if (mapped) icb_rdat[r*32 +: 32] = rd;
    for (int c = 0; c <= ack_cyc; c++) begin
      @(posedge clk); #1;
      req_i  = 1'b1;
      we_i   = (c == 0) ? we   : 1'($urandom);
      addr_i = (c == 0) ? addr : $urandom;
      data_i = (c == 0) ? wd   : $urandom;
      if (c == 0 || c == ack_cyc) a = NREG'($urandom);
      else a = NREG'($urandom) & ~oh;
      if (mapped && c == 1 + d) a = a | oh;
      icb_ack = a;
      @(negedge clk);
      exp_wr  = (mapped && c == 1 &&  we) ? oh : '0;
      exp_rd  = (mapped && c == 1 && !we) ? oh : '0;
      exp_ack = (c == ack_cyc);
      exp_d   = exp_ack ? exp_data : last_data;
      vectors++;
      if (icb_wr !== exp_wr || icb_rd !== exp_rd) begin
        errors++;
        $display("FAIL strobe addr=%h cyc=%0d: wr=%b rd=%b, want wr=%b rd=%b",
                 addr, c, icb_wr, icb_rd, exp_wr, exp_rd);
      end
      vectors++;
      if (ack_o !== exp_ack || (exp_ack && err_o !== exp_err)) begin
        errors++;
        $display("FAIL ack addr=%h cyc=%0d: ack=%b err=%b, want ack=%b err=%b",
                 addr, c, ack_o, err_o, exp_ack, exp_err);
      end
      vectors++;
      if (data_o !== exp_d) begin
        errors++;
        $display("FAIL data addr=%h cyc=%0d: data=%h, want %h", addr, c, data_o, exp_d);
      end
      if (mapped && c >= 1) begin
        vectors++;
        if (icb_adr !== addr[19:0] || icb_wdat !== wd) begin
          errors++;
          $display("FAIL bus addr=%h cyc=%0d: adr=%h wdat=%h, want adr=%h wdat=%h",
                   addr, c, icb_adr, icb_wdat, addr[19:0], wd);
        end
      end
    end
    last_data = exp_data;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0;
    icb_ack = '0; icb_rdat = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({data_o, ack_o, err_o, icb_wr, icb_rd, icb_adr, icb_wdat} !== '0) begin
      errors++;
      $display("FAIL reset: data=%h ack=%b err=%b wr=%b rd=%b adr=%h wdat=%h, want all 0",
               data_o, ack_o, err_o, icb_wr, icb_rd, icb_adr, icb_wdat);
    end
    @(posedge clk); #1 rst = 1'b0;
    last_data = 32'h0;
    idle(2);
  endtask

  task automatic test_write();
    run_access(1'b1, 32'h0000_0104, 32'h1234_5678, 0, 32'h0);
    idle(1);
  endtask

  task automatic test_read_wait();
    run_access(1'b0, 32'h0020_0010, 32'h0, 3, 32'hCAFE_F00D);
    idle(2);
  endtask

  task automatic test_unmapped();
    run_access(1'b0, 32'h0FF0_0000, 32'h0, 0, 32'h5555_AAAA);
    idle(1);
    run_access(1'b1, 32'h0040_0000, 32'h9999_0000, 0, 32'h0);
    idle(1);
  endtask

  task automatic test_timeout();
`ifdef REGIONAL_TIMEOUT_EN
    run_access(1'b0, 32'h0010_0000, 32'h0, NEVER, 32'h1111_2222);
    idle(2);
`else
    @(posedge clk); #1;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0010_0000; icb_ack = '0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      icb_ack = NREG'($urandom) & 4'b1101;
      @(negedge clk);
      vectors++;
      if (ack_o !== 1'b0 || icb_rd !== ((c == 1) ? 4'b0010 : 4'b0000)) begin
        errors++;
        $display("FAIL silent cyc=%0d: ack=%b rd=%b, want ack=0 rd=%b",
                 c, ack_o, icb_rd, (c == 1) ? 4'b0010 : 4'b0000);
      end
    end
    @(posedge clk); #1 rst = 1'b1; req_i = 1'b0; icb_ack = '0;
    @(posedge clk); #1 rst = 1'b0;
    last_data = 32'h0;
    idle(2);
`endif
  endtask

  task automatic test_foreign_ack_and_reset();
    @(posedge clk); #1;
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0040; data_i = 32'hDEAD_BEEF; icb_ack = '0;
    @(posedge clk); #1 icb_ack = '0;
    @(posedge clk); #1 icb_ack = 4'b0010;
    @(negedge clk);
    vectors++;
    if (ack_o !== 1'b0) begin errors++; $display("FAIL foreign_ack: ack=%b, want 0", ack_o); end
    @(posedge clk); #1 icb_ack = '0;
    @(negedge clk);
    vectors++;
    if (ack_o !== 1'b0) begin errors++; $display("FAIL foreign_ack_after: ack=%b, want 0", ack_o); end
    @(posedge clk); #1 rst = 1'b1; req_i = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    last_data = 32'h0;
    @(negedge clk);
    vectors++;
    if ({data_o, ack_o, err_o, icb_wr, icb_rd, icb_adr, icb_wdat} !== '0) begin
      errors++;
      $display("FAIL midreset: data=%h ack=%b err=%b wr=%b rd=%b adr=%h wdat=%h, want all 0",
               data_o, ack_o, err_o, icb_wr, icb_rd, icb_adr, icb_wdat);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1 icb_ack = 4'b0001;
      @(negedge clk);
      vectors++;
      if (ack_o !== 1'b0 || icb_wr !== '0) begin
        errors++;
        $display("FAIL stale_ack cyc=%0d: ack=%b wr=%b, want ack=0 wr=0", c, ack_o, icb_wr);
      end
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 32'h0000_0020, 32'hA5A5_0001, 0, 32'h0);
    run_access(1'b1, 32'h0030_0008, 32'hA5A5_0002, 0, 32'h0);
    run_access(1'b0, 32'h0010_0004, 32'h0, 0, 32'h0BAD_F00D);
    run_access(1'b0, 32'h0070_0004, 32'h0, 0, 32'h0);
    run_access(1'b0, 32'h0020_0000, 32'h0, 1, 32'h7777_1234);
    idle(1);
  endtask

  task automatic test_random();
    logic [7:0]  r;
    logic [31:0] addr;
    int          d;
    for (int i = 0; i < 60; i++) begin
      r = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 5));
      addr = {4'($urandom), r, 20'($urandom)};
      d = $urandom_range(0, 4);
`ifdef REGIONAL_TIMEOUT_EN
      if ($urandom_range(0, 9) == 0) d = NEVER;
`endif
      run_access(1'($urandom), addr, $urandom, d, $urandom);
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_unmapped();
    test_timeout();
    test_foreign_ack_and_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
